mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be:
- ACCESS_CYCLES, default 5: number of cycles an external memory request is held (legal range 1..15).
- BASE_ADDR, default 1024: byte address mapped to memory word 0.

REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset.
- MEM_R_EN  in  1  load request from the EX/MEM register.
- MEM_W_EN  in  1  store request from the EX/MEM register.
- ALU_result  in  32  byte address of the access.
- ST_val  in  32  store data.
- mem_rdata  in  32  read data from the external memory.
- Mem_read_value  out  32  load result, fed to the MEM/WB register.
- ready  out  1  high when the access is complete or no access is pending; low means freeze the pipeline.
- mem_addr  out  16  external word address.
- mem_wdata  out  32  external write data.
- mem_we  out  1  external write strobe.
- mem_re  out  1  external read strobe.

Function
REQ-003 Address translation SHALL be combinational: mem_addr = bits [17:2] of (ALU_result - BASE_ADDR), 32-bit subtraction with wrap-around; no range check.
REQ-004 mem_wdata SHALL equal ST_val combinationally.
REQ-005 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-006 Request definition: req = MEM_R_EN | MEM_W_EN. If MEM_R_EN and MEM_W_EN are both high, the access SHALL be a write.
REQ-007 IDLE with req=1: next state SHALL be ACCESS, with the cycle counter loaded to ACCESS_CYCLES and the access type (read/write) latched.
REQ-008 IDLE with req=0: the FSM SHALL remain in IDLE.
REQ-009 ACCESS strobes: mem_re (read) or mem_we (write) SHALL be high in every ACCESS cycle and low in every other state.
REQ-010 ACCESS counting: the counter SHALL decrement once per ACCESS cycle. When the counter equals 1, next state SHALL be DONE, and on that same edge Mem_read_value SHALL capture mem_rdata if the access is a read.
REQ-011 DONE SHALL last exactly one cycle and then go to IDLE unconditionally. A request still asserted during DONE SHALL NOT start a new access.
REQ-012 ready SHALL be combinational:
- 1 in IDLE when req=0;
- 1 in DONE;
- 0 in IDLE when req=1;
- 0 in ACCESS.
REQ-013 Latency: for a request first seen in IDLE at cycle t, ready SHALL be high in cycle t+ACCESS_CYCLES+1.
REQ-014 Back-to-back requests: a request present in the IDLE cycle following DONE SHALL start a new access immediately; there SHALL be no extra bubble.
REQ-015 Mem_read_value SHALL hold its value across writes and idle cycles, changing only on a read capture or reset.
REQ-016 Input changes during ACCESS SHALL NOT alter the latched access type. mem_addr and mem_wdata track the inputs, which a frozen upstream holds stable.

Reset
REQ-017 On a posedge clk with rst=1, the block SHALL:
- set the state to IDLE, the counter to 0 and the latched type to read;
- set Mem_read_value to 32'h0;
- take priority over all other activity.
REQ-018 During and immediately after reset, mem_we and mem_re SHALL be 0.
REQ-019 Reset asserted mid-ACCESS SHALL abort the access: no capture into Mem_read_value, mem_we low from the next cycle, ready=1 if req=0.

Verification
REQ-020 Read (ACCESS_CYCLES=5): MEM_R_EN=1, ALU_result=1032, mem_rdata=32'hDEADBEEF -> mem_addr=16'd2; mem_re high for 5 cycles; ready high in cycle 6; Mem_read_value=32'hDEADBEEF after the cycle-5 edge.
REQ-021 Write: MEM_W_EN=1, ALU_result=1024, ST_val=32'h12345678 -> mem_addr=0; mem_wdata=32'h12345678; mem_we high exactly 5 cycles; Mem_read_value unchanged; ready high in cycle 6.
REQ-022 Idle: MEM_R_EN=MEM_W_EN=0 for 10 cycles -> ready=1 throughout; mem_we=mem_re=0 throughout.
REQ-023 Back-to-back: a read then a write with no gap -> the second ACCESS begins in the cycle after DONE; total 14 cycles from first request to second ready; strobes never overlap.
REQ-024 Reset mid-access: rst pulsed in the 3rd ACCESS cycle of a read -> next cycle IDLE; Mem_read_value=0; mem_re=0.
REQ-025 Both enables high with ACCESS_CYCLES=1 -> write performed; mem_we high 1 cycle; ready high in cycle 2.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns EX/MEM load/store requests into
// a fixed-length external memory access and freezes the pipeline meanwhile.
module mem_access_ctrl #(
   parameter int unsigned ACCESS_CYCLES = 5,
   parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   input  logic [31:0] ALU_result,
   input  logic [31:0] ST_val,
   input  logic [31:0] mem_rdata,
   output logic [31:0] Mem_read_value,
   output logic        ready,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES);

   state_t      state;
   state_t      state_nx;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nx;
   logic        is_wr;
   logic        is_wr_nx;
   logic        capture;
   logic        req;
   logic [31:0] offset;
   logic [15:0] offset_unused;

   assign req           = MEM_R_EN | MEM_W_EN;
   assign offset        = ALU_result - BASE_ADDR;
   assign mem_addr      = offset[17:2];
   assign offset_unused = {offset[31:18], offset[1:0]};
   assign mem_wdata     = ST_val;

   // State, counter, access type and load result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= 4'd0;
         is_wr          <= 1'b0;
         Mem_read_value <= 32'h0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         is_wr <= is_wr_nx;
         if (capture) begin
            Mem_read_value <= mem_rdata;
         end
      end
   end

   // Next-state, counter, strobes and pipeline-freeze decode
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      is_wr_nx = is_wr;
      capture  = 1'b0;
      ready    = 1'b0;
      mem_we   = 1'b0;
      mem_re   = 1'b0;
      unique case (state)
         IDLE: begin
            ready = ~req;
            if (req) begin
               state_nx = ACCESS;
               cnt_nx   = CNT_INIT;
               is_wr_nx = MEM_W_EN;
            end
         end
         ACCESS: begin
            mem_we = is_wr;
            mem_re = ~is_wr;
            cnt_nx = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nx = DONE;
               capture  = ~is_wr;
            end
         end
         DONE: begin
            ready    = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: read, write, idle, back-to-back,
// reset abort, and a one-cycle access with both enables high.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] ALU_result;
   logic [31:0] ST_val;
   logic [31:0] mem_rdata;

   logic [31:0] rv5;
   logic        rdy5;
   logic [15:0] addr5;
   logic [31:0] wd5;
   logic        we5;
   logic        re5;

   logic [31:0] rv1;
   logic        rdy1;
   logic [15:0] addr1;
   logic [31:0] wd1;
   logic        we1;
   logic        re1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.ACCESS_CYCLES(5), .BASE_ADDR(32'd1024)) dut5 (
      .clk(clk), .rst(rst),
      .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .ALU_result(ALU_result), .ST_val(ST_val), .mem_rdata(mem_rdata),
      .Mem_read_value(rv5), .ready(rdy5), .mem_addr(addr5),
      .mem_wdata(wd5), .mem_we(we5), .mem_re(re5)
   );

   mem_access_ctrl #(.ACCESS_CYCLES(1), .BASE_ADDR(32'd1024)) dut1 (
      .clk(clk), .rst(rst),
      .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .ALU_result(ALU_result), .ST_val(ST_val), .mem_rdata(mem_rdata),
      .Mem_read_value(rv1), .ready(rdy1), .mem_addr(addr1),
      .mem_wdata(wd1), .mem_we(we1), .mem_re(re1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // drive point: just after the rising edge
   task automatic drv();
      @(posedge clk);
      #1;
   endtask

   // sample point: falling edge
   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      rst        = 1'b1;
      MEM_R_EN   = 1'b0;
      MEM_W_EN   = 1'b0;
      ALU_result = 32'd1024;
      ST_val     = 32'h0;
      mem_rdata  = 32'h0;

      // reset
      smp();
      chk("rst_we", {31'b0, we5}, 32'd0);
      chk("rst_re", {31'b0, re5}, 32'd0);
      drv();
      rst = 1'b0;
      smp();
      chk("rst_ready", {31'b0, rdy5}, 32'd1);
      chk("rst_rv", rv5, 32'h0);
      chk("rst_we2", {31'b0, we5}, 32'd0);

      // read
      drv();
      MEM_R_EN   = 1'b1;
      ALU_result = 32'd1032;
      mem_rdata  = 32'hDEADBEEF;
      smp();
      chk("rd_addr", {16'b0, addr5}, 32'd2);
      chk("rd_ready_t0", {31'b0, rdy5}, 32'd0);
      chk("rd_re_t0", {31'b0, re5}, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         drv();
         smp();
         chk($sformatf("rd_re_c%0d", i), {31'b0, re5}, 32'd1);
         chk($sformatf("rd_we_c%0d", i), {31'b0, we5}, 32'd0);
         chk($sformatf("rd_rdy_c%0d", i), {31'b0, rdy5}, 32'd0);
      end
      drv();
      smp();
      chk("rd_ready_c6", {31'b0, rdy5}, 32'd1);
      chk("rd_re_c6", {31'b0, re5}, 32'd0);
      chk("rd_value", rv5, 32'hDEADBEEF);
      drv();
      MEM_R_EN = 1'b0;
      smp();
      chk("rd_idle_ready", {31'b0, rdy5}, 32'd1);

      // write
      drv();
      MEM_W_EN   = 1'b1;
      ALU_result = 32'd1024;
      ST_val     = 32'h12345678;
      mem_rdata  = 32'h55555555;
      smp();
      chk("wr_addr", {16'b0, addr5}, 32'd0);
      chk("wr_wdata", wd5, 32'h12345678);
      chk("wr_ready_t0", {31'b0, rdy5}, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         drv();
         smp();
         chk($sformatf("wr_we_c%0d", i), {31'b0, we5}, 32'd1);
         chk($sformatf("wr_re_c%0d", i), {31'b0, re5}, 32'd0);
      end
      drv();
      smp();
      chk("wr_ready_c6", {31'b0, rdy5}, 32'd1);
      chk("wr_we_c6", {31'b0, we5}, 32'd0);
      chk("wr_rv_hold", rv5, 32'hDEADBEEF);
      drv();
      MEM_W_EN = 1'b0;

      // idle
      for (int i = 0; i < 10; i++) begin
         smp();
         chk($sformatf("idle_rdy%0d", i), {31'b0, rdy5}, 32'd1);
         chk($sformatf("idle_str%0d", i), {30'b0, we5, re5}, 32'd0);
         drv();
      end
      chk("idle_rv_hold", rv5, 32'hDEADBEEF);

      // back-to-back read then write
      MEM_R_EN   = 1'b1;
      ALU_result = 32'd1100;
      mem_rdata  = 32'hCAFEF00D;
      for (int k = 0; k <= 13; k++) begin
         if (k == 7) begin
            MEM_R_EN = 1'b0;
            MEM_W_EN = 1'b1;
            ST_val   = 32'h0BADF00D;
         end
         smp();
         chk($sformatf("b2b_rdy%0d", k), {31'b0, rdy5},
             {31'b0, (k == 6 || k == 13)});
         chk($sformatf("b2b_re%0d", k), {31'b0, re5},
             {31'b0, (k >= 1 && k <= 5)});
         chk($sformatf("b2b_we%0d", k), {31'b0, we5},
             {31'b0, (k >= 8 && k <= 12)});
         drv();
      end
      MEM_W_EN = 1'b0;
      chk("b2b_rv", rv5, 32'hCAFEF00D);

      // reset in the 3rd ACCESS cycle of a read
      drv();
      MEM_R_EN  = 1'b1;
      mem_rdata = 32'h11111111;
      smp();
      drv();
      smp();
      drv();
      smp();
      drv();
      rst      = 1'b1;
      MEM_R_EN = 1'b0;
      smp();
      chk("abort_re_c3", {31'b0, re5}, 32'd1);
      drv();
      rst = 1'b0;
      smp();
      chk("abort_re", {31'b0, re5}, 32'd0);
      chk("abort_we", {31'b0, we5}, 32'd0);
      chk("abort_ready", {31'b0, rdy5}, 32'd1);
      chk("abort_rv", rv5, 32'h0);
      drv();
      smp();
      chk("abort_rv_hold", rv5, 32'h0);

      // both enables, one access cycle
      drv();
      MEM_R_EN   = 1'b1;
      MEM_W_EN   = 1'b1;
      ALU_result = 32'd1028;
      ST_val     = 32'h0000ABCD;
      mem_rdata  = 32'h77777777;
      smp();
      chk("both_addr", {16'b0, addr1}, 32'd1);
      chk("both_ready_t0", {31'b0, rdy1}, 32'd0);
      drv();
      smp();
      chk("both_we_c1", {31'b0, we1}, 32'd1);
      chk("both_re_c1", {31'b0, re1}, 32'd0);
      chk("both_wdata", wd1, 32'h0000ABCD);
      drv();
      MEM_R_EN = 1'b0;
      MEM_W_EN = 1'b0;
      smp();
      chk("both_ready_c2", {31'b0, rdy1}, 32'd1);
      chk("both_we_c2", {31'b0, we1}, 32'd0);
      chk("both_rv", rv1, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
